// File: rtl/darkriscv_mc.sv
// Multi-cycle RV32I/RV32E integer core with request/acknowledge instruction fetch.
// Loads, stores, SYSTEM and anything else unimplemented halt the core with a sticky trap.
module darkriscv_mc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NREGS    = 32,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RES,
    output logic             IREQ,
    output logic [31:0]      IADDR,
    input  logic             IACK,
    input  logic [31:0]      IDATA,
    output logic             RETIRE,
    output logic [CNT_W-1:0] INSTRET,
    output logic             TRAP,
    input  logic [4:0]       DBG_RSEL,
    output logic [31:0]      DBG_RDATA,
    output logic [31:0]      DEBUG
);

    localparam bit RV32E = (NREGS == 16);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;

    state_t           state_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      ir_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             ireq_reg;
    logic             trap_reg;
    logic [31:0]      rf_reg [1:NREGS-1];

    // x0 and indices beyond the implemented file read as zero
    function automatic logic [31:0] rf_read(input logic [4:0] idx);
        logic [31:0] val;
        val = 32'h0;
        for (int i = 1; i < NREGS; i++) begin
            if (idx == 5'(i)) begin
                val = rf_reg[i];
            end
        end
        return val;
    endfunction

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc_plus4;

    assign opcode   = ir_reg[6:0];
    assign rd       = ir_reg[11:7];
    assign f3       = ir_reg[14:12];
    assign rs1      = ir_reg[19:15];
    assign rs2      = ir_reg[24:20];
    assign f7       = ir_reg[31:25];
    assign imm_i    = {{20{ir_reg[31]}}, ir_reg[31:20]};
    assign imm_b    = {{19{ir_reg[31]}}, ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0};
    assign imm_u    = {ir_reg[31:12], 12'h000};
    assign imm_j    = {{11{ir_reg[31]}}, ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0};
    assign rs1_val  = rf_read(rs1);
    assign rs2_val  = rf_read(rs2);
    assign pc_plus4 = pc_reg + 32'd4;

    logic        illegal;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] pc_next;
    logic [31:0] target;
    logic        take;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic        alt;
    logic [31:0] opb;
    logic [31:0] alu_res;

    // Shared ALU for OP and OP-IMM; alt selects SUB/SRA
    always_comb begin
        opb     = (opcode == 7'b0010011) ? imm_i : rs2_val;
        alt     = (opcode == 7'b0110011) ? f7[5] : (f3 == 3'b101 && f7[5]);
        alu_res = 32'h0;
        case (f3)
            3'b000:  alu_res = (alt && opcode == 7'b0110011) ? rs1_val - opb : rs1_val + opb;
            3'b001:  alu_res = rs1_val << opb[4:0];
            3'b010:  alu_res = {31'h0, $signed(rs1_val) < $signed(opb)};
            3'b011:  alu_res = {31'h0, rs1_val < opb};
            3'b100:  alu_res = rs1_val ^ opb;
            3'b101:  alu_res = alt ? 32'($signed(rs1_val) >>> opb[4:0]) : rs1_val >> opb[4:0];
            3'b110:  alu_res = rs1_val | opb;
            default: alu_res = rs1_val & opb;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        wr_en   = 1'b0;
        wr_data = 32'h0;
        pc_next = pc_plus4;
        target  = 32'h0;
        take    = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            7'b0110111: begin
                use_rd  = 1'b1;
                wr_en   = 1'b1;
                wr_data = imm_u;
            end
            7'b0010111: begin
                use_rd  = 1'b1;
                wr_en   = 1'b1;
                wr_data = pc_reg + imm_u;
            end
            7'b1101111: begin
                use_rd  = 1'b1;
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                take    = 1'b1;
                target  = pc_reg + imm_j;
            end
            7'b1100111: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wr_en   = 1'b1;
                wr_data = pc_plus4;
                take    = 1'b1;
                target  = (rs1_val + imm_i) & 32'hFFFF_FFFE;
                illegal = (f3 != 3'b000);
            end
            7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                target  = pc_reg + imm_b;
                case (f3)
                    3'b000:  take = (rs1_val == rs2_val);
                    3'b001:  take = (rs1_val != rs2_val);
                    3'b100:  take = ($signed(rs1_val) < $signed(rs2_val));
                    3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
                    3'b110:  take = (rs1_val < rs2_val);
                    3'b111:  take = (rs1_val >= rs2_val);
                    default: illegal = 1'b1;
                endcase
            end
            7'b0010011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                wr_en   = 1'b1;
                wr_data = alu_res;
                if (f3 == 3'b001 && f7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
                if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) begin
                    illegal = 1'b1;
                end
            end
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_en   = 1'b1;
                wr_data = alu_res;
                if (!(f7 == 7'b0000000 ||
                      (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))) begin
                    illegal = 1'b1;
                end
            end
            7'b0001111: begin
                illegal = (f3 != 3'b000);
            end
            default: illegal = 1'b1;
        endcase
        if (take) begin
            pc_next = target;
            if (target[1:0] != 2'b00) begin
                illegal = 1'b1;
            end
        end
        if (RV32E && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4]))) begin
            illegal = 1'b1;
        end
    end

    logic commit;
    assign commit = (state_reg == EXEC) && !illegal;

    always_ff @(posedge CLK) begin
        if (RES) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
            ir_reg    <= 32'h0;
            cnt_reg   <= '0;
            ireq_reg  <= 1'b0;
            trap_reg  <= 1'b0;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= FETCH;
                    ireq_reg  <= 1'b1;
                end
                FETCH: begin
                    if (IACK) begin
                        ir_reg    <= IDATA;
                        state_reg <= EXEC;
                        ireq_reg  <= 1'b0;
                    end
                end
                EXEC: begin
                    if (illegal) begin
                        state_reg <= HALT;
                        trap_reg  <= 1'b1;
                    end else begin
                        pc_reg    <= pc_next;
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                        state_reg <= FETCH;
                        ireq_reg  <= 1'b1;
                    end
                end
                HALT: state_reg <= HALT;
                default: state_reg <= BOOT;
            endcase
        end
    end

    // One always_ff per architectural register; x0 is never stored
    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_rf
            always_ff @(posedge CLK) begin
                if (RES) begin
                    rf_reg[gi] <= 32'h0;
                end else if (commit && wr_en && rd == 5'(gi)) begin
                    rf_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign IREQ      = ireq_reg;
    assign IADDR     = pc_reg;
    assign RETIRE    = commit;
    assign INSTRET   = cnt_reg;
    assign TRAP      = trap_reg;
    assign DBG_RDATA = rf_read(DBG_RSEL);
    assign DEBUG     = pc_reg;

endmodule

// File: doc/darkriscv_mc.md
# darkriscv_mc

Parametrised multi-cycle RV32I/RV32E integer core, the successor to the LUI/AUIPC-only core. It fetches instructions over a request/acknowledge port instead of a free-running instruction input. It executes the full integer ALU, jump and branch subset, counts retired instructions, and halts on a sticky trap for anything it does not implement. Data memory is out of scope: loads and stores trap.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- NREGS, 32: register-file size; 32 = RV32I, 16 = RV32E. Any other value is unsupported.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RES  in  1  synchronous, active-high reset.
- IREQ  out  1  fetch request; high exactly while in FETCH.
- IADDR  out  32  fetch address = PC; valid while IREQ high.
- IACK  in  1  fetch acknowledge; IDATA is valid in the same cycle.
- IDATA  in  32  instruction word.
- RETIRE  out  1  one-cycle pulse per completed instruction.
- INSTRET  out  CNT_W  retired-instruction count.
- TRAP  out  1  sticky halt flag.
- DBG_RSEL  in  5  register index for debug read.
- DBG_RDATA  out  32  combinational read of register DBG_RSEL; reads 0 for x0 and for indices >= NREGS.
- DEBUG  out  32  current PC.

## Operation
- States: BOOT, FETCH, EXEC, HALT.
- BOOT: entered on reset. Always moves to FETCH in the next cycle.
- FETCH: IREQ=1, IADDR=PC. On a rising edge with IACK=1, latch IDATA into IR and go to EXEC. Otherwise stay in FETCH with IREQ held and IADDR stable.
- EXEC (one cycle): decode IR, write rd, update PC, and pulse RETIRE, then return to FETCH. On an illegal or faulting instruction, go to HALT instead, with no register write, no PC change and no RETIRE.
- HALT: TRAP=1, IREQ=0. Only RES leaves HALT.
- Supported instructions:
  - LUI and AUIPC (AUIPC adds the PC of the instruction itself).
  - JAL, and JALR with funct3=000. JALR target = (rs1+imm) & ~1.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - MISC-MEM (FENCE): executes as a NOP and retires.
- Illegal instructions, which send the core to HALT:
  - any other opcode, including LOAD, STORE and SYSTEM;
  - an unlisted funct3/funct7 combination;
  - shift-immediate with imm[11:5] not 0000000 (or 0100000 for SRAI);
  - NREGS=16 with any used rd/rs1/rs2 field having bit 4 set.
- Misaligned target: a jump, or a taken branch, whose target has bits[1:0]!=0 traps. A not-taken branch never traps.
- Arithmetic:
  - All arithmetic is 32-bit modulo 2^32.
  - Shift amount = low 5 bits.
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. SLTIU sign-extends the immediate before the unsigned compare.
  - Immediates are sign-extended per RISC-V encoding.
  - PC+4 wraps at 2^32.
- x0 reads 0 always; writes to x0 are discarded. JAL/JALR with rd=0 still jump.
- INSTRET increments on each RETIRE and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset values:
  - state=BOOT, PC=RESET_PC, IR=0, all registers 0, INSTRET=0.
  - IREQ=0, RETIRE=0, TRAP=0, DEBUG=RESET_PC.
- RES overrides everything, including mid-fetch with IREQ high and HALT. An IACK in a RES cycle is ignored.
- IACK is ignored outside FETCH.
- First IREQ=1 appears in the 2nd cycle after RES deasserts: the first cycle is BOOT.
- Minimum 2 cycles per instruction with IACK tied high. Each cycle of IACK=0 in FETCH adds one cycle.
- RETIRE is high during EXEC only.
- Register write, PC update and INSTRET increment are visible on DBG_RDATA, DEBUG and INSTRET in the cycle after EXEC.
- TRAP rises in the cycle after the trapping EXEC and stays high.

## Test plan
- Reset/boot: RESET_PC=32'h100, hold RES 3 cycles -> IREQ=0 during reset and BOOT; IREQ=1 with IADDR=32'h100 in the 2nd cycle after release; INSTRET=0.
- Fetch wait states: IACK low for 4 cycles, then LUI x5,0x12345 -> IADDR stable throughout; x5=32'h12345000; RETIRE pulses once; DEBUG=32'h104; INSTRET=1.
- ALU sweep:
  - ADDI x1,x0,-1 -> x1=32'hFFFFFFFF;
  - SRAI x2,x1,4 -> x2=32'hFFFFFFFF;
  - SRLI x3,x1,28 -> x3=32'hF;
  - SLTU x4,x0,x1 -> x4=1;
  - SLT x6,x1,x0 -> x6=1;
  - SUB x7,x0,x1 -> x7=1;
  - ADDI x0,x0,5 -> x0 stays 0.
- Control flow:
  - BEQ x0,x0,+8 at 32'h200 -> next IADDR=32'h208;
  - BNE x0,x0,+8 -> next IADDR is PC+4;
  - JAL x1,-16 at 32'h300 -> x1=32'h304, IADDR=32'h2F0;
  - JALR with rs1+imm=32'h401 -> IADDR=32'h400.
- Traps:
  - LW, ECALL and 32'h0 each -> TRAP=1, IREQ=0, no RETIRE, PC and registers unchanged;
  - JAL +2 -> trap;
  - an untaken BNE to +2 -> no trap.
  - RES then clears TRAP and restarts from RESET_PC.
- RV32E and counter wrap:
  - NREGS=16: ADDI x16,x0,1 -> trap.
  - CNT_W=4: 17 NOPs -> INSTRET=1.
